// File: rtl/store_split_unit_pkg.sv
// Shared definitions for the store path.
// - FNC_*          : store width encodings carried in func3
// - store_state_e  : beat sequencer states
package store_split_unit_pkg;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;
  localparam logic [2:0] FNC_SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } store_state_e;

endpackage

// File: rtl/store_lane_shift.sv
// Combinational byte-lane placement for one store request.
// Ports:
//   data      in  DWIDTH   store data, LSB-aligned
//   offset    in  OFFW     byte offset inside the bus word
//   func3     in  3        store width code
//   mask      out 2*NB     byte enables across two consecutive bus words
//   wdata     out 2*DWIDTH data placed on those lanes, unused lanes zero
//   has_beat1 out 1        store spills into the second bus word
//   illegal   out 1        func3 not supported at this bus width
module store_lane_shift
  import store_split_unit_pkg::*;
#(
  parameter int DWIDTH = 32,
  localparam int NB = DWIDTH / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [DWIDTH-1:0]   data,
  input  logic [OFFW-1:0]     offset,
  input  logic [2:0]          func3,
  output logic [2*NB-1:0]     mask,
  output logic [2*DWIDTH-1:0] wdata,
  output logic                has_beat1,
  output logic                illegal
);

  logic [NB-1:0]     size_mask;
  logic [DWIDTH-1:0] trunc_data;

  // Keep only the bytes covered by the access width; the rest are zeroed so
  // that disabled lanes never carry stale data after the shift.
  always_comb begin
    size_mask  = '0;
    trunc_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << func3[1:0])) begin
        size_mask[i]        = 1'b1;
        trunc_data[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  assign mask      = {{NB{1'b0}}, size_mask} << offset;
  assign wdata     = {{DWIDTH{1'b0}}, trunc_data} << {offset, 3'b000};
  assign has_beat1 = |mask[2*NB-1:NB];
  assign illegal   = func3[2] || ((func3 == FNC_SD) && (DWIDTH == 32));

endmodule

// File: rtl/store_split_unit.sv
// Store path between execute and data memory / MMIO write port. Turns one
// store request into one or two registered byte-enable write beats.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_addr, req_data, req_func3 byte address, LSB-aligned data, width
//   mem_valid/mem_ready           write beat handshake
//   mem_addr, mem_wea, mem_wdata  bus-aligned address, byte enables, data
//   misalign_err, illegal_err     one-cycle pulses for dropped requests
//   busy                          a beat is outstanding
//
// state | meaning
// IDLE  | no beat outstanding, ready for a request
// BEAT0 | first (or only) beat presented on mem_*
// BEAT1 | second beat of a word-crossing store presented on mem_*
module store_split_unit
  import store_split_unit_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_data,
  input  logic [2:0]          req_func3,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH/8-1:0] mem_wea,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic                misalign_err,
  output logic                illegal_err,
  output logic                busy
);

  localparam int NB   = DWIDTH / 8;
  localparam int OFFW = $clog2(NB);

  logic [2*NB-1:0]     sh_mask;
  logic [2*DWIDTH-1:0] sh_wdata;
  logic                sh_has_beat1;
  logic                sh_illegal;

  store_lane_shift #(.DWIDTH(DWIDTH)) u_lane_shift (
    .data      (req_data),
    .offset    (req_addr[OFFW-1:0]),
    .func3     (req_func3),
    .mask      (sh_mask),
    .wdata     (sh_wdata),
    .has_beat1 (sh_has_beat1),
    .illegal   (sh_illegal)
  );

  store_state_e      state;
  logic              pend_beat1;
  logic [AWIDTH-1:0] beat1_addr;
  logic [NB-1:0]     beat1_wea;
  logic [DWIDTH-1:0] beat1_wdata;

  logic [AWIDTH-1:0] base_addr;
  logic              last_beat;
  logic              accept;
  logic              drop_misalign;

  assign base_addr     = {req_addr[AWIDTH-1:OFFW], {OFFW{1'b0}}};
  assign last_beat     = (state == BEAT1) || ((state == BEAT0) && !pend_beat1);
  // Ready also on the completing cycle so single-beat stores stream at one
  // per cycle.
  assign req_ready     = (state == IDLE) || (mem_valid && mem_ready && last_beat);
  assign accept        = req_valid && req_ready;
  assign drop_misalign = sh_has_beat1 && (ALLOW_MISALIGNED == 0);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wea      <= '0;
      mem_wdata    <= '0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      pend_beat1   <= 1'b0;
      beat1_addr   <= '0;
      beat1_wea    <= '0;
      beat1_wdata  <= '0;
    end else begin
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      if ((state == BEAT0) && mem_ready && pend_beat1) begin
        state      <= BEAT1;
        mem_addr   <= beat1_addr;
        mem_wea    <= beat1_wea;
        mem_wdata  <= beat1_wdata;
        pend_beat1 <= 1'b0;
      end else if (req_ready) begin
        // Either idle or the last beat completes this cycle.
        if (accept && !sh_illegal && !drop_misalign) begin
          state       <= BEAT0;
          mem_valid   <= 1'b1;
          mem_addr    <= base_addr;
          mem_wea     <= sh_mask[NB-1:0];
          mem_wdata   <= sh_wdata[DWIDTH-1:0];
          pend_beat1  <= sh_has_beat1;
          beat1_addr  <= base_addr + AWIDTH'(NB);
          beat1_wea   <= sh_mask[2*NB-1:NB];
          beat1_wdata <= sh_wdata[2*DWIDTH-1:DWIDTH];
        end else begin
          state      <= IDLE;
          mem_valid  <= 1'b0;
          mem_wea    <= '0;
          mem_wdata  <= '0;
          pend_beat1 <= 1'b0;
        end
        illegal_err  <= accept && sh_illegal;
        misalign_err <= accept && !sh_illegal && drop_misalign;
      end
    end
  end

endmodule
